// File: rtl/clock_alarm.sv
// Compare/alarm peripheral: raises irq when the tick count reaches a programmed target (one-shot or periodic).
// Latency: bus access acknowledged 1 cycle after bus_valid; match -> PENDING/CAPTURE/irq on the next edge.
// Backpressure: none; each access completes in one cycle, a held bus_valid yields one access per 2 cycles.
module clock_alarm #(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [31:0]       time_in,
    input  logic              bus_valid,
    output logic              bus_ready,
    input  logic [3:0]        bus_wstrb,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic [31:0]       bus_wdata,
    output logic [31:0]       bus_rdata,
    output logic              irq
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        FIRED = 2'd2
    } state_t;

    state_t      state;
    state_t      state_n;

    logic [2:0]  ctrl;        // {IE, PERIODIC, EN}
    logic [31:0] compare;
    logic [31:0] period;
    logic        pending;
    logic        overrun;
    logic [31:0] capture;

    logic        access;
    logic        wr;
    logic [2:0]  word;
    logic        wr_ctrl;
    logic        wr_cmp;
    logic        wr_per;
    logic        wr_status;
    logic [1:0]  status_clr;
    logic [31:0] ctrl_merged;
    logic [31:0] cmp_merged;
    logic [31:0] per_merged;
    logic [31:0] diff;
    logic        reached;
    logic        match;
    logic        reload;
    logic [31:0] rd_mux;
    logic        unused_bits;

    // Replace only the byte lanes selected by the write strobes.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                res[i*8 +: 8] = new_val[i*8 +: 8];
            end
        end
        return res;
    endfunction

    // An access starts on the first cycle of bus_valid; the ack cycle itself is never a new access.
    assign access    = bus_valid & ~bus_ready;
    assign wr        = access & (bus_wstrb != 4'b0000);
    assign word      = bus_addr[4:2];
    assign wr_ctrl   = wr & (word == 3'd0);
    assign wr_cmp    = wr & (word == 3'd1);
    assign wr_per    = wr & (word == 3'd2);
    assign wr_status = wr & (word == 3'd3);

    // STATUS bits live in byte 0, so only lane 0 can clear them.
    assign status_clr = {2{wr_status & bus_wstrb[0]}} & bus_wdata[1:0];

    assign ctrl_merged = merge_lanes({29'd0, ctrl}, bus_wdata, bus_wstrb);
    assign cmp_merged  = merge_lanes(compare, bus_wdata, bus_wstrb);
    assign per_merged  = merge_lanes(period, bus_wdata, bus_wstrb);

    // Wrap-safe "reached or passed": the difference lies in the forward half of the ring.
    assign diff    = time_in - compare;
    assign reached = ~diff[31];

    assign unused_bits = ^{bus_addr[1:0], ctrl_merged[31:3], diff[30:0]};

    // FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state and match qualification; a CTRL/COMPARE write owns the cycle and suppresses the match.
    always_comb begin
        state_n = state;
        match   = 1'b0;
        reload  = 1'b0;
        if (wr_ctrl) begin
            state_n = ctrl_merged[0] ? ARMED : IDLE;
        end else begin
            case (state)
                ARMED: begin
                    if (reached && !wr_cmp) begin
                        match = 1'b1;
                        if (ctrl[1] && (period != 32'd0)) begin
                            reload = 1'b1;
                        end else begin
                            state_n = FIRED;
                        end
                    end
                end
                IDLE:    state_n = IDLE;
                FIRED:   state_n = FIRED;
                default: state_n = IDLE;
            endcase
        end
    end

    // Register read multiplexer; words 6-7 read as zero.
    always_comb begin
        rd_mux = 32'd0;
        case (word)
            3'd0:    rd_mux = {29'd0, ctrl};
            3'd1:    rd_mux = compare;
            3'd2:    rd_mux = period;
            3'd3:    rd_mux = {30'd0, overrun, pending};
            3'd4:    rd_mux = capture;
            3'd5:    rd_mux = time_in;
            default: rd_mux = 32'd0;
        endcase
    end

    // Bus response registers: one-cycle ack with data sampled before the edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus_ready <= 1'b0;
            bus_rdata <= 32'd0;
        end else begin
            bus_ready <= access;
            bus_rdata <= access ? rd_mux : 32'd0;
        end
    end

    // Programmable registers, periodic reload and match side effects; a match set beats a STATUS clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ctrl    <= 3'd0;
            compare <= 32'd0;
            period  <= 32'd0;
            pending <= 1'b0;
            overrun <= 1'b0;
            capture <= 32'd0;
        end else begin
            if (wr_ctrl) begin
                ctrl <= ctrl_merged[2:0];
            end
            if (wr_cmp) begin
                compare <= cmp_merged;
            end else if (reload) begin
                compare <= compare + period;
            end
            if (wr_per) begin
                period <= per_merged;
            end
            if (match) begin
                capture <= time_in;
            end
            pending <= (pending & ~status_clr[0]) | match;
            overrun <= (overrun & ~status_clr[1]) | (match & pending);
        end
    end

    // Interrupt is a pure function of registered state.
    assign irq = pending & ctrl[2];

endmodule

// File: tb/tb_clock_alarm.sv
// Bench for clock_alarm: cycle-stepped driver with a behavioural model of the register map and alarm rules.
// Each tick advances time_in by one and checks bus_ready, bus_rdata and irq against the model.
// Scenario tasks add explicit checks taken straight from the expected behaviour.
module tb_clock_alarm;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] time_in = 32'd0;
    logic        bus_valid = 1'b0;
    logic        bus_ready;
    logic [3:0]  bus_wstrb = 4'd0;
    logic [4:0]  bus_addr = 5'd0;
    logic [31:0] bus_wdata = 32'd0;
    logic [31:0] bus_rdata;
    logic        irq;

    int n_cmp = 0;
    int n_err = 0;
    int irq_rises = 0;
    logic last_irq = 1'b0;

    // Behavioural model state
    logic [2:0]  m_ctrl;
    logic [31:0] m_cmp, m_per, m_cap, m_rdata;
    logic        m_pend, m_ovr, m_armed, m_ready;

    clock_alarm #(.ADDR_W(5)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .time_in   (time_in),
        .bus_valid (bus_valid),
        .bus_ready (bus_ready),
        .bus_wstrb (bus_wstrb),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] lanes(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (s[i]) r[i*8 +: 8] = n[i*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] mread(input logic [2:0] w);
        case (w)
            3'd0:    return {29'd0, m_ctrl};
            3'd1:    return m_cmp;
            3'd2:    return m_per;
            3'd3:    return {30'd0, m_ovr, m_pend};
            3'd4:    return m_cap;
            3'd5:    return time_in;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_ctrl = 3'd0; m_cmp = 32'd0; m_per = 32'd0; m_cap = 32'd0; m_rdata = 32'd0;
        m_pend = 1'b0; m_ovr = 1'b0; m_armed = 1'b0; m_ready = 1'b0;
    endtask

    // One clock: evolve model from the inputs present at the edge, then compare DUT outputs.
    task automatic tick();
        logic        acc, wr, hit, np, no;
        logic [2:0]  w;
        logic [31:0] t, d, cm;
        logic [1:0]  clr;
        t   = time_in;
        acc = bus_valid && !m_ready;
        wr  = acc && (bus_wstrb != 4'd0);
        w   = bus_addr[4:2];
        d   = t - m_cmp;
        hit = m_armed && (d < 32'h8000_0000) && !(wr && (w == 3'd0 || w == 3'd1));
        m_rdata = acc ? mread(w) : 32'd0;
        clr = (wr && w == 3'd3 && bus_wstrb[0]) ? bus_wdata[1:0] : 2'b00;
        np  = (m_pend & ~clr[0]) | hit;
        no  = (m_ovr & ~clr[1]) | (hit & m_pend);
        if (hit) begin
            m_cap = t;
            if (m_ctrl[1] && m_per != 32'd0) m_cmp = m_cmp + m_per;
            else m_armed = 1'b0;
        end
        if (wr && w == 3'd0) begin
            cm = lanes({29'd0, m_ctrl}, bus_wdata, bus_wstrb);
            m_ctrl  = cm[2:0];
            m_armed = cm[0];
        end
        if (wr && w == 3'd1) m_cmp = lanes(m_cmp, bus_wdata, bus_wstrb);
        if (wr && w == 3'd2) m_per = lanes(m_per, bus_wdata, bus_wstrb);
        m_pend  = np;
        m_ovr   = no;
        m_ready = acc;
        @(posedge clk);
        #1;
        n_cmp += 3;
        if (bus_ready !== m_ready) begin
            n_err++; $display("FAIL ready t=%h got %b want %b", t, bus_ready, m_ready);
        end
        if (bus_rdata !== m_rdata) begin
            n_err++; $display("FAIL rdata t=%h got %h want %h", t, bus_rdata, m_rdata);
        end
        if (irq !== (m_pend & m_ctrl[2])) begin
            n_err++; $display("FAIL irq t=%h got %b want %b", t, irq, m_pend & m_ctrl[2]);
        end
        if (irq && !last_irq) irq_rises++;
        last_irq = irq;
        time_in = time_in + 32'd1;
    endtask

    task automatic bus_access(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                              output logic [31:0] r);
        bus_addr = a; bus_wdata = d; bus_wstrb = s; bus_valid = 1'b1;
        tick();
        r = bus_rdata;
        bus_valid = 1'b0; bus_wstrb = 4'd0;
        tick();
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        logic [31:0] r;
        bus_access(a, d, 4'hF, r);
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] r);
        bus_access(a, 32'd0, 4'h0, r);
    endtask

    task automatic test_reset();
        logic [31:0] r;
        bus_addr = 5'h14; bus_wstrb = 4'd0; bus_valid = 1'b1;
        tick();
        #2 resetn = 1'b0;
        #1;
        n_cmp++;
        if (bus_ready !== 1'b0 || irq !== 1'b0 || bus_rdata !== 32'd0) begin
            n_err++;
            $display("FAIL reset_async got ready=%b irq=%b rdata=%h want 0", bus_ready, irq, bus_rdata);
        end
        model_reset();
        bus_valid = 1'b0;
        last_irq = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rd(5'(i * 4), r);
            n_cmp++;
            if (r !== 32'd0) begin
                n_err++; $display("FAIL reset_reg%0d got %h want 0", i, r);
            end
        end
    endtask

    task automatic test_oneshot();
        logic [31:0] c, t, r;
        wr(5'h00, 0); wr(5'h0C, 3);
        c = $urandom_range(32'h4000_0000, 1000);
        time_in = c - 12;
        wr(5'h04, c);
        wr(5'h00, 32'h5);
        repeat (18) begin
            t = time_in;
            tick();
            n_cmp++;
            if (irq !== (t >= c)) begin
                n_err++; $display("FAIL oneshot_irq t=%0d got %b want %b", t, irq, t >= c);
            end
        end
        rd(5'h10, r);
        n_cmp++;
        if (r !== c) begin n_err++; $display("FAIL oneshot_capture got %h want %h", r, c); end
        rd(5'h0C, r);
        n_cmp++;
        if (r !== 32'd1) begin n_err++; $display("FAIL oneshot_status got %h want 1", r); end
        rd(5'h04, r);
        n_cmp++;
        if (r !== c) begin n_err++; $display("FAIL oneshot_compare got %h want %h", r, c); end
    endtask

    task automatic test_periodic();
        logic [31:0] c, r;
        int guard;
        wr(5'h00, 0); wr(5'h0C, 3);
        c = $urandom_range(32'h4000_0000, 1000);
        time_in = c - 10;
        wr(5'h04, c);
        wr(5'h08, 20);
        irq_rises = 0;
        wr(5'h00, 32'h7);
        guard = 0;
        while (time_in < c + 55 && guard < 200) begin
            if (irq) wr(5'h0C, 32'h1);
            else tick();
            guard++;
        end
        n_cmp++;
        if (irq_rises != 3) begin n_err++; $display("FAIL periodic_count got %0d want 3", irq_rises); end
        rd(5'h04, r);
        n_cmp++;
        if (r !== c + 60) begin n_err++; $display("FAIL periodic_compare got %h want %h", r, c + 60); end
        rd(5'h10, r);
        n_cmp++;
        if (r !== c + 40) begin n_err++; $display("FAIL periodic_capture got %h want %h", r, c + 40); end
    endtask

    task automatic test_wrap();
        logic [31:0] t, r;
        logic exp;
        wr(5'h00, 0); wr(5'h0C, 3);
        time_in = 32'hFFFF_FFE8;
        wr(5'h04, 32'h5);
        wr(5'h00, 32'h5);
        repeat (37) begin
            t = time_in;
            tick();
            exp = (t < 32'h8000_0000) && (t >= 32'd5);
            n_cmp++;
            if (irq !== exp) begin n_err++; $display("FAIL wrap_irq t=%h got %b want %b", t, irq, exp); end
        end
        rd(5'h10, r);
        n_cmp++;
        if (r !== 32'd5) begin n_err++; $display("FAIL wrap_capture got %h want 5", r); end
    endtask

    task automatic test_overrun();
        logic [31:0] r;
        wr(5'h00, 0); wr(5'h0C, 3);
        wr(5'h08, 32'd1);
        wr(5'h04, time_in + 32'd6);
        wr(5'h00, 32'h7);
        repeat (8) tick();
        rd(5'h0C, r);
        n_cmp++;
        if (r !== 32'd3) begin n_err++; $display("FAIL overrun_status got %h want 3", r); end
        wr(5'h0C, 32'h3);
        rd(5'h0C, r);
        n_cmp++;
        if (r[0] !== 1'b1) begin n_err++; $display("FAIL clear_vs_set got %h want pending 1", r); end
    endtask

    task automatic test_bus();
        logic [31:0] r;
        logic [5:0]  pat;
        wr(5'h00, 0);
        bus_addr = 5'h14; bus_wstrb = 4'd0; bus_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            pat[i] = bus_ready;
        end
        bus_valid = 1'b0;
        tick();
        n_cmp++;
        if (pat !== 6'b010101) begin n_err++; $display("FAIL held_valid got %b want 010101", pat); end
        wr(5'h04, 0);
        bus_access(5'h04, 32'hAABB_CCDD, 4'b0010, r);
        rd(5'h04, r);
        n_cmp++;
        if (r !== 32'h0000_CC00) begin n_err++; $display("FAIL byte_lane got %h want 0000cc00", r); end
        wr(5'h18, 32'hFFFF_FFFF);
        rd(5'h18, r);
        n_cmp++;
        if (r !== 32'd0) begin n_err++; $display("FAIL addr18 got %h want 0", r); end
        rd(5'h1C, r);
        n_cmp++;
        if (r !== 32'd0) begin n_err++; $display("FAIL addr1c got %h want 0", r); end
    endtask

    task automatic test_random();
        logic [31:0] d, r;
        logic [4:0]  a;
        logic [3:0]  s;
        for (int i = 0; i < 150; i++) begin
            a = 5'($urandom_range(7, 0) * 4);
            s = ($urandom_range(1, 0) == 0) ? 4'd0 : 4'($urandom_range(15, 1));
            d = $urandom;
            if (a == 5'h04) d = time_in + $urandom_range(30, 0);
            if (a == 5'h08) d = $urandom_range(8, 0);
            bus_access(a, d, s, r);
            repeat ($urandom_range(3, 0)) tick();
        end
    endtask

    initial begin
        model_reset();
        time_in = $urandom;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        test_reset();
        test_oneshot();
        test_periodic();
        test_wrap();
        test_overrun();
        test_bus();
        test_random();
        wr(5'h00, 32'h7);
        wr(5'h0C, 32'h3);
        repeat (3) tick();
        test_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
